// File: rtl/psg_noise_pkg.sv
// Shared definitions for the PSG noise generator and its receive-side checker.
// Holds the default LFSR geometry, the feedback function and the checker state type.
package psg_noise_pkg;

  localparam int unsigned PSG_LFSR_BITS = 17;
  localparam int unsigned PSG_LFSR_TAP0 = 0;
  localparam int unsigned PSG_LFSR_TAP1 = 3;

  typedef enum logic {
    StFill,
    StCheck
  } noise_state_e;

  // State is zero-extended to 32 bits; the all-zero check forces a 1 so the LFSR never sticks.
  function automatic logic lfsr_feedback(input logic [31:0] state,
                                         input logic [4:0]  tap0,
                                         input logic [4:0]  tap1);
    return (state[tap0] ^ state[tap1]) | (state == 32'd0);
  endfunction

endpackage

// File: rtl/strobe_interval.sv
// Measures the number of clk cycles between the last two sample strobes.
// The free-running counter and the reported interval both saturate at all-ones.
module strobe_interval #(
  parameter int unsigned INTERVAL_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample,
  output logic [INTERVAL_BITS-1:0] interval,
  output logic                     interval_valid
);

  localparam logic [INTERVAL_BITS-1:0] CntMax = '1;
  localparam logic [INTERVAL_BITS-1:0] CntOne = INTERVAL_BITS'(1);

  logic [INTERVAL_BITS-1:0] cnt_q, cnt_d;
  logic [INTERVAL_BITS-1:0] interval_q, interval_d;
  logic                     seen_q, seen_d;
  logic                     valid_q, valid_d;

  always_comb begin
    cnt_d      = cnt_q;
    interval_d = interval_q;
    seen_d     = seen_q;
    valid_d    = valid_q;
    if (sample) begin
      interval_d = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;
      cnt_d      = '0;
      seen_d     = 1'b1;
      // Only the second strobe after reset closes a complete interval.
      if (seen_q) begin
        valid_d = 1'b1;
      end
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      interval_q <= '0;
      seen_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
      seen_q     <= seen_d;
      valid_q    <= valid_d;
    end
  end

  assign interval       = interval_q;
  assign interval_valid = valid_q;

endmodule

// File: rtl/noise_checker.sv
// Rebuilds the PSG noise LFSR state from observed output bits and flags mispredictions.
// Also reports the clk interval between shift strobes.
module noise_checker
  import psg_noise_pkg::*;
#(
  parameter int unsigned LFSR_BITS     = PSG_LFSR_BITS,
  parameter int unsigned LFSR_TAP0     = PSG_LFSR_TAP0,
  parameter int unsigned LFSR_TAP1     = PSG_LFSR_TAP1,
  parameter int unsigned LOCK_RUN      = 17,
  parameter int unsigned ERR_BITS      = 8,
  parameter int unsigned INTERVAL_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample,
  input  logic                     noise_in,
  input  logic                     clear_errors,
  output logic                     locked,
  output logic                     mismatch,
  output logic [ERR_BITS-1:0]      err_count,
  output logic [INTERVAL_BITS-1:0] interval,
  output logic                     interval_valid
);

  localparam int unsigned FillW = $clog2(LFSR_BITS + 1);
  localparam int unsigned RunW  = $clog2(LOCK_RUN + 1);

  localparam logic [FillW-1:0]    FillLast = FillW'(LFSR_BITS - 1);
  localparam logic [FillW-1:0]    FillOne  = FillW'(1);
  localparam logic [RunW-1:0]     RunMax   = RunW'(LOCK_RUN);
  localparam logic [RunW-1:0]     RunOne   = RunW'(1);
  localparam logic [ERR_BITS-1:0] ErrMax   = '1;
  localparam logic [ERR_BITS-1:0] ErrOne   = ERR_BITS'(1);
  localparam logic [4:0]          Tap0Idx  = 5'(LFSR_TAP0);
  localparam logic [4:0]          Tap1Idx  = 5'(LFSR_TAP1);

  noise_state_e          state_q, state_d;
  logic [LFSR_BITS-1:0]  sh_q, sh_d;
  logic [FillW-1:0]      fill_q, fill_d;
  logic [RunW-1:0]       run_q, run_d;
  logic                  locked_q, locked_d;
  logic                  mismatch_q, mismatch_d;
  logic [ERR_BITS-1:0]   err_q, err_d;
  logic                  bit_in;
  logic                  pred;

  assign bit_in = ~noise_in;
  assign pred   = lfsr_feedback(32'(sh_q), Tap0Idx, Tap1Idx);

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    fill_d     = fill_q;
    run_d      = run_q;
    locked_d   = locked_q;
    mismatch_d = 1'b0;
    // Clear applies first so a coincident mismatch leaves a count of one.
    err_d      = clear_errors ? '0 : err_q;

    if (sample) begin
      sh_d = {bit_in, sh_q[LFSR_BITS-1:1]};
      unique case (state_q)
        StFill: begin
          if (fill_q == FillLast) begin
            state_d = StCheck;
            fill_d  = '0;
            run_d   = '0;
          end else begin
            fill_d = fill_q + FillOne;
          end
        end
        StCheck: begin
          if (bit_in == pred) begin
            if (run_q != RunMax) begin
              run_d = run_q + RunOne;
            end
            locked_d = (run_d == RunMax);
          end else begin
            mismatch_d = 1'b1;
            locked_d   = 1'b0;
            state_d    = StFill;
            fill_d     = '0;
            run_d      = '0;
            if (err_d != ErrMax) begin
              err_d = err_d + ErrOne;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFill;
      sh_q       <= '0;
      fill_q     <= '0;
      run_q      <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      fill_q     <= fill_d;
      run_q      <= run_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  strobe_interval #(
    .INTERVAL_BITS(INTERVAL_BITS)
  ) u_strobe_interval (
    .clk           (clk),
    .reset         (reset),
    .sample        (sample),
    .interval      (interval),
    .interval_valid(interval_valid)
  );

  assign locked    = locked_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_noise_checker.sv
// Directed bench for noise_checker: table-driven short sequences plus generator-driven
// lock, mismatch, saturation, interval and reset scenarios.
module tb_noise_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample;
  logic        noise_in;
  logic        clear_errors;
  logic        locked;
  logic        mismatch;
  logic [7:0]  err_count;
  logic [15:0] interval;
  logic        interval_valid;

  int checks = 0;
  int errors = 0;

  logic [16:0] g;

  typedef struct {
    int         rep;
    logic       smp;
    logic       nb;
    logic       clr;
    logic       e_lock;
    logic       e_mis;
    logic [7:0] e_err;
  } vec_t;

  vec_t tbl[10];

  noise_checker dut (
    .clk           (clk),
    .reset         (reset),
    .sample        (sample),
    .noise_in      (noise_in),
    .clear_errors  (clear_errors),
    .locked        (locked),
    .mismatch      (mismatch),
    .err_count     (err_count),
    .interval      (interval),
    .interval_valid(interval_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the next negedge with outputs reflecting the strobe.
  task automatic strobe(input logic nb, input logic clr);
    sample       = 1'b1;
    noise_in     = nb;
    clear_errors = clr;
    @(negedge clk);
    sample       = 1'b0;
    clear_errors = 1'b0;
  endtask

  task automatic do_reset(input logic smp);
    reset    = 1'b1;
    sample   = smp;
    noise_in = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    sample   = 1'b0;
  endtask

  // Generator model: next bit follows the 17-bit recurrence over previous outputs.
  task automatic gen_strobe(input logic inv);
    logic b;
    b = (g[0] ^ g[3]) | (g == 17'd0);
    g = {b, g[16:1]};
    strobe(~b ^ inv, 1'b0);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_interval"}, 32'(interval), 32'd0);
    check({tag, "_ivalid"}, 32'(interval_valid), 32'd0);
  endtask

  initial begin
    tbl[0] = '{17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[2] = '{17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[3] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[4] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[5] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[6] = '{16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[9] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};

    reset        = 1'b1;
    sample       = 1'b0;
    noise_in     = 1'b1;
    clear_errors = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all_reset("por");

    // Generator stream with a sample during reset, one inverted bit at strobe 50.
    do_reset(1'b1);
    g = '0;
    for (int i = 1; i <= 90; i++) begin
      gen_strobe(i == 50);
      check($sformatf("gen_locked_%0d", i), 32'(locked),
            32'(((i >= 34) && (i < 50)) || (i >= 84)));
      check($sformatf("gen_mismatch_%0d", i), 32'(mismatch), 32'(i == 50));
      check($sformatf("gen_err_%0d", i), 32'(err_count), 32'(i >= 50));
    end

    // Table: zero-window rule, refill, clear without a strobe, short prediction runs.
    do_reset(1'b0);
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        if (tbl[r].smp) begin
          strobe(tbl[r].nb, tbl[r].clr);
        end else begin
          clear_errors = tbl[r].clr;
          @(negedge clk);
          clear_errors = 1'b0;
        end
      end
      check($sformatf("tbl_locked_%0d", r), 32'(locked), 32'(tbl[r].e_lock));
      check($sformatf("tbl_mismatch_%0d", r), 32'(mismatch), 32'(tbl[r].e_mis));
      check($sformatf("tbl_err_%0d", r), 32'(err_count), 32'(tbl[r].e_err));
    end

    // Error counter saturation, then clear coincident with a mismatch.
    do_reset(1'b0);
    for (int m = 1; m <= 300; m++) begin
      repeat (17) strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      if (m == 255 || m == 300) begin
        check($sformatf("sat_mismatch_%0d", m), 32'(mismatch), 32'd1);
        check($sformatf("sat_err_%0d", m), 32'(err_count), 32'd255);
      end
    end
    repeat (17) strobe(1'b1, 1'b0);
    check("clr_pre_err", 32'(err_count), 32'd255);
    strobe(1'b1, 1'b1);
    check("clr_mismatch", 32'(mismatch), 32'd1);
    check("clr_err", 32'(err_count), 32'd1);

    // Strobe interval measurement.
    do_reset(1'b0);
    strobe(1'b0, 1'b0);
    check("iv_first_valid", 32'(interval_valid), 32'd0);
    repeat (31) @(negedge clk);
    strobe(1'b0, 1'b0);
    check("iv_32_a", 32'(interval), 32'd32);
    check("iv_32_a_valid", 32'(interval_valid), 32'd1);
    repeat (31) @(negedge clk);
    strobe(1'b0, 1'b0);
    check("iv_32_b", 32'(interval), 32'd32);
    strobe(1'b0, 1'b0);
    check("iv_back_to_back", 32'(interval), 32'd1);
    repeat (69999) @(negedge clk);
    strobe(1'b0, 1'b0);
    check("iv_saturate", 32'(interval), 32'd65535);
    check("iv_saturate_valid", 32'(interval_valid), 32'd1);

    // Reset while locked, then relock from scratch.
    do_reset(1'b0);
    g = '0;
    repeat (40) gen_strobe(1'b0);
    check("ml_locked", 32'(locked), 32'd1);
    check("ml_ivalid", 32'(interval_valid), 32'd1);
    do_reset(1'b0);
    check_all_reset("ml_rst");
    g = '0;
    for (int i = 1; i <= 34; i++) begin
      gen_strobe(1'b0);
      if (i >= 33) begin
        check($sformatf("relock_%0d", i), 32'(locked), 32'(i == 34));
      end
    end
    check("relock_err", 32'(err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noise_checker.md
# noise_checker

Receive-side companion to the PSG noise generator. Samples the generator's 1-bit noise output once per LFSR shift strobe and rebuilds the generator state from the observed bits. Once synchronised, predicts every following bit and flags deviations. Used in the self-test/monitor path to prove noise-channel integrity, and measures the clock interval between shifts to confirm the programmed noise period.

## Interface

Parameters:
- LFSR_BITS, 17, generator LFSR width
- LFSR_TAP0, 0, first feedback tap
- LFSR_TAP1, 3, second feedback tap
- LOCK_RUN, 17, consecutive correct predictions needed to assert locked
- ERR_BITS, 8, error counter width
- INTERVAL_BITS, 16, shift-interval counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- sample  in  1  one-cycle strobe, asserted once per generator LFSR shift
- noise_in  in  1  generator output; the LFSR bit is ~noise_in
- clear_errors  in  1  zeroes err_count
- locked  out  1  prediction is trusted
- mismatch  out  1  one-cycle pulse on a mispredicted bit
- err_count  out  ERR_BITS  saturating mismatch count
- interval  out  INTERVAL_BITS  clk cycles between the last two sample strobes
- interval_valid  out  1  interval holds a real measurement

## Operation

- On each sample cycle, b = ~noise_in is captured.
- Shadow register sh[LFSR_BITS-1:0] shifts right with b entering at the MSB. sh[0] is the oldest bit in the window.
- Prediction for the next b: p = (sh[LFSR_TAP0] ^ sh[LFSR_TAP1]) | (sh == 0). This matches the generator recurrence o[t+17] = f(o[t..t+16]).
- Mismatch is evaluated only in CHECK. Predictions in FILL are ignored.

States:
- FILL: fill_cnt counts captured bits. After LFSR_BITS captures, go to CHECK with run_cnt = 0.
- CHECK:
  - Match (b == p): run_cnt increments, saturating at LOCK_RUN. locked = (run_cnt == LOCK_RUN).
  - Mismatch: mismatch pulses, err_count increments, locked drops, and the state returns to FILL with fill_cnt = 0.
  - The mismatching bit is still shifted into sh, but the full window is refilled before prediction resumes.

Counters and flags:
- err_count saturates at 2^ERR_BITS − 1.
- clear_errors zeroes err_count. If clear_errors and a mismatch occur in the same cycle, the result is err_count = 1.
- Interval counter:
  - Increments every clk and saturates at all-ones.
  - On sample, interval ← counter + 1 and the counter resets to 0.
  - interval_valid sets on the second sample after reset.

## Timing

- Reset values: locked 0, mismatch 0, err_count 0, interval 0, interval_valid 0, state FILL, sh 0, fill_cnt 0, run_cnt 0.
- All outputs are registered. mismatch, locked, err_count and interval update in the cycle after the sample cycle (latency 1).
- sample on consecutive cycles is legal. Each strobe is processed independently, with no back-pressure.
- A sample asserted in the same cycle as reset is discarded.
- Reset while locked returns the block to FILL immediately. Lock takes at least LFSR_BITS + LOCK_RUN strobes after reset.
- From reset, locked first rises one cycle after strobe 34 (defaults).
- A mismatch on the strobe that would have completed the lock run still counts as a mismatch. locked is never asserted in that case.

## Structure

- Shared package `psg_noise_pkg`:
  - LFSR_BITS, LFSR_TAP0, LFSR_TAP1 defaults, also used by the generator.
  - Function lfsr_feedback(state) returning (tap0 ^ tap1) | (state == 0).
  - State enum FILL/CHECK.
- One natural sub-module, `strobe_interval`: the saturating cycle counter with interval/interval_valid.

## Test plan

- Generator model (from reset, period 1) drives 60 strobes → locked=1 one cycle after strobe 34; mismatch never pulses; err_count=0.
- Locked stream; invert noise_in at strobe 50 → mismatch pulse one cycle after; err_count=1; locked=0; locked returns one cycle after strobe 84 (50+17+17).
- noise_in held at 1 (LFSR bits all 0) for 17 strobes, then noise_in=1 again → prediction b=1 (zero rule), observed b=0 → mismatch, err_count=1.
- Strobes every 32 clk → interval=32, interval_valid=1 after the second strobe; a gap of 70000 clk → interval=65535.
- 300 forced mismatches with ERR_BITS=8 → err_count=255; clear_errors coincident with a mismatch → err_count=1.
- Reset asserted mid-lock for 1 cycle → all outputs return to their reset values the next cycle; relock takes 34 strobes.
